// File: rtl/serial_divider.sv
// Sequential restoring divider: one quotient bit per clock, done pulse with held results.
// A divisor of zero completes in one cycle with an all-ones quotient and the dividend as remainder.
module serial_divider #(
    parameter int DVD_WID = 32,
    parameter int DVS_WID = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DVD_WID-1:0] dividend,
    input  logic [DVS_WID-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [DVD_WID-1:0] quotient,
    output logic [DVS_WID-1:0] remainder,
    output logic               div_by_zero,
    output logic [1:0]         dbg_state
);

    // Handshake: start is accepted only while busy is low (IDLE or DONE); done is a
    // one-cycle strobe and quotient/remainder/div_by_zero hold until the next accepted start.

    localparam int CW = (DVD_WID > 1) ? $clog2(DVD_WID) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DVS_WID-1:0] div_r;
    logic [DVD_WID-1:0] q_r;
    logic [DVS_WID-1:0] r_r;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               last;
    logic [DVS_WID:0]   shifted;
    logic [DVS_WID:0]   trial;
    logic [DVS_WID-1:0] step_r;
    logic [DVD_WID-1:0] step_q;
    logic [DVS_WID-1:0] dz_rem;

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;
    assign last      = (cnt == CW'(DVD_WID - 1));

    // The partial remainder always ends a step below the divisor, so DVS_WID bits hold it.
    always_comb begin
        shifted = {r_r, q_r[DVD_WID-1]};
        trial   = shifted - {1'b0, div_r};
        if (!trial[DVS_WID]) begin
            step_r = trial[DVS_WID-1:0];
            step_q = {q_r[DVD_WID-2:0], 1'b1};
        end else begin
            step_r = shifted[DVS_WID-1:0];
            step_q = {q_r[DVD_WID-2:0], 1'b0};
        end
    end

    generate
        if (DVD_WID >= DVS_WID) begin : g_dz_trunc
            assign dz_rem = dividend[DVS_WID-1:0];
        end else begin : g_dz_ext
            assign dz_rem = {{(DVS_WID-DVD_WID){1'b0}}, dividend};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r       <= '0;
            q_r         <= '0;
            r_r         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_r <= divisor;
            q_r   <= dividend;
            r_r   <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dz_rem;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= '0;
                remainder   <= '0;
                div_by_zero <= 1'b0;
            end
        end else if (state == RUN) begin
            r_r <= step_r;
            q_r <= step_q;
            cnt <= cnt + CW'(1);
            if (last) begin
                quotient  <= step_q;
                remainder <= step_r;
            end
        end
    end

endmodule
